// File: rtl/sifh_hist_fsm.sv
// Read-modify-write controller that builds a TDC timestamp histogram in an external dual-port RAM.
// Optional macro SIFH_SAT_EN: saturate bin counts at full scale instead of wrapping.
module sifh_hist_fsm #(
   parameter int NP       = 10,
   parameter int NB       = 6,
   parameter int PEAK_MAX = 8
) (
   input  logic                clk,
   input  logic                res,
   input  logic                wrEn,
   input  logic [NP-1:0]       data,
   input  logic [PEAK_MAX-1:0] counts,
   output logic [NB-1:0]       waddr,
   output logic [NB-1:0]       raddr,
   output logic                wEnable,
   output logic                rEnable,
   output logic                writeFlag,
   output logic                readFlag,
   output logic [PEAK_MAX-1:0] newCounts
);

   typedef enum logic {CLEAR, ACCUM} state_t;

   state_t              state, stateNext;
   logic [NB-1:0]       clrAddr, clrAddrNext;
   logic [NB-1:0]       dataBin;
   logic [NB-1:0]       raddrNext, waddrNext;
   logic                readNext, writeNext;
   logic [PEAK_MAX-1:0] newCountsNext, base;

   logic                vld_p1, vld_p2, vldNext_p1;
   logic [NB-1:0]       bin_p1, bin_p2, binNext_p1;
   logic                fwdVld;
   logic [NB-1:0]       fwdAddr;
   logic [PEAK_MAX-1:0] fwdVal;

   function automatic logic [PEAK_MAX-1:0] incCount(input logic [PEAK_MAX-1:0] cnt);
`ifdef SIFH_SAT_EN
      incCount = (&cnt) ? cnt : cnt + 1'b1;
`else
      incCount = cnt + 1'b1;
`endif
   endfunction

   assign dataBin = data[NP-1 -: NB];

   // The RAM read misses the write being driven now and the one that committed on the read edge.
   always_comb begin
      if (wEnable && (waddr == bin_p2))
         base = newCounts;
      else if (fwdVld && (fwdAddr == bin_p2))
         base = fwdVal;
      else
         base = counts;
   end

   always_comb begin
      stateNext     = state;
      clrAddrNext   = clrAddr;
      raddrNext     = raddr;
      readNext      = 1'b0;
      waddrNext     = waddr;
      newCountsNext = newCounts;
      writeNext     = 1'b0;
      vldNext_p1    = 1'b0;
      binNext_p1    = bin_p1;
      case (state)
         CLEAR: begin
            waddrNext     = clrAddr;
            newCountsNext = '0;
            writeNext     = 1'b1;
            clrAddrNext   = clrAddr + 1'b1;
            if (&clrAddr)
               stateNext = ACCUM;
         end
         ACCUM: begin
            if (wrEn) begin
               raddrNext  = dataBin;
               readNext   = 1'b1;
               vldNext_p1 = 1'b1;
               binNext_p1 = dataBin;
            end
            if (vld_p2) begin
               waddrNext     = bin_p2;
               newCountsNext = incCount(base);
               writeNext     = 1'b1;
            end
         end
         default: stateNext = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state     <= CLEAR;
         clrAddr   <= '0;
         raddr     <= '0;
         waddr     <= '0;
         newCounts <= '0;
         wEnable   <= 1'b0;
         writeFlag <= 1'b0;
         readFlag  <= 1'b0;
         rEnable   <= 1'b1;
         vld_p1    <= 1'b0;
         bin_p1    <= '0;
         vld_p2    <= 1'b0;
         bin_p2    <= '0;
         fwdVld    <= 1'b0;
         fwdAddr   <= '0;
         fwdVal    <= '0;
      end else begin
         state     <= stateNext;
         clrAddr   <= clrAddrNext;
         // Stage p0 -> p1: read issue
         raddr     <= raddrNext;
         readFlag  <= readNext;
         rEnable   <= ~readNext;
         vld_p1    <= vldNext_p1;
         bin_p1    <= binNext_p1;
         // Stage p1 -> p2: RAM read in flight
         vld_p2    <= vld_p1;
         bin_p2    <= bin_p1;
         // Stage p2 -> write: increment and write back, keep last write for forwarding
         waddr     <= waddrNext;
         newCounts <= newCountsNext;
         wEnable   <= writeNext;
         writeFlag <= writeNext;
         fwdVld    <= wEnable;
         fwdAddr   <= waddr;
         fwdVal    <= newCounts;
      end
   end

endmodule

// File: tb/tb_sifh_hist_fsm.sv
// Bench for sifh_hist_fsm: behavioural histogram model plus RAM model, random and directed stimulus.
module tb_sifh_hist_fsm;
   localparam int NP = 10;
   localparam int NB = 6;
   localparam int PM = 8;

   logic          clk = 1'b0;
   logic          res, wrEn;
   logic [NP-1:0] data;
   logic [PM-1:0] counts = '0;
   logic [NB-1:0] waddr, raddr;
   logic          wEnable, rEnable, writeFlag, readFlag;
   logic [PM-1:0] newCounts;

   int checks = 0;
   int errors = 0;

   sifh_hist_fsm #(.NP(NP), .NB(NB), .PEAK_MAX(PM)) dut (
      .clk(clk), .res(res), .wrEn(wrEn), .data(data), .counts(counts),
      .waddr(waddr), .raddr(raddr), .wEnable(wEnable), .rEnable(rEnable),
      .writeFlag(writeFlag), .readFlag(readFlag), .newCounts(newCounts)
   );

   always #5 clk = ~clk;

   // Dual-port RAM: reads return the pre-write contents on a same-edge collision.
   logic [PM-1:0] mem [64];
   always @(posedge clk) begin
      if (!rEnable && readFlag) counts <= mem[raddr];
      if (wEnable && writeFlag) mem[waddr] <= newCounts;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bump(input int v);
`ifdef SIFH_SAT_EN
      return (v == 255) ? 255 : v + 1;
`else
      return (v + 1) % 256;
`endif
   endfunction

   // Model: every accepted event increments its bin once; read shows 1 cycle later, write 2 after that.
   int hist [64];
   int clearLeft, clrIdx, b;
   bit modelOn = 0;
   bit p1v, p2v;
   int p1b, p2b, p1c, p2c;
   int eRaddr, eWaddr, eNew;
   bit eRd, eWen;

   always @(posedge clk) begin
      if (res) begin
         modelOn = 1; clearLeft = 64; clrIdx = 0; p1v = 0; p2v = 0;
         foreach (hist[i]) hist[i] = 0;
         eRaddr = 0; eWaddr = 0; eNew = 0; eRd = 0; eWen = 0;
      end else if (clearLeft > 0) begin
         eWen = 1; eWaddr = clrIdx; eNew = 0; eRd = 0;
         clrIdx++; clearLeft--;
      end else begin
         eWen = p2v;
         if (p2v) begin eWaddr = p2b; eNew = p2c; end
         p2v = p1v; p2b = p1b; p2c = p1c;
         eRd = wrEn; p1v = wrEn;
         if (wrEn) begin
            b = int'(data[NP-1 -: NB]);
            hist[b] = bump(hist[b]);
            eRaddr = b; p1b = b; p1c = hist[b];
         end
      end
   end

   always @(negedge clk) begin
      if (modelOn) begin
         chk("raddr", int'(raddr), eRaddr);
         chk("readFlag", int'(readFlag), int'(eRd));
         chk("rEnable", int'(rEnable), int'(!eRd));
         chk("waddr", int'(waddr), eWaddr);
         chk("newCounts", int'(newCounts), eNew);
         chk("wEnable", int'(wEnable), int'(eWen));
         chk("writeFlag", int'(writeFlag), int'(eWen));
      end
   end

   task automatic randCycles(input int n, input int lo, input int hi);
      for (int i = 0; i < n; i++) begin
         wrEn = ($urandom_range(0, 99) < 60);
         data = {6'($urandom_range(lo, hi)), 4'($urandom)};
         @(negedge clk);
      end
      wrEn = 0;
   endtask

   int bins3 [3] = '{511, 200, 511};
   int wa3   [3] = '{31, 12, 31};
   int nc3   [3] = '{1, 1, 2};

   initial begin
      res = 1; wrEn = 0; data = '0;
      @(negedge clk);
      chk("rst_raddr", int'(raddr), 0);
      chk("rst_waddr", int'(waddr), 0);
      chk("rst_newCounts", int'(newCounts), 0);
      chk("rst_wEnable", int'(wEnable), 0);
      chk("rst_readFlag", int'(readFlag), 0);
      chk("rst_rEnable", int'(rEnable), 1);
      res = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         chk("clr_waddr", int'(waddr), i);
         chk("clr_wEnable", int'(wEnable), 1);
         chk("clr_rEnable", int'(rEnable), 1);
      end
      // single event, data=108 -> bin 6
      data = 10'd108; wrEn = 1;
      @(negedge clk); wrEn = 0;
      chk("ev_raddr", int'(raddr), 6);
      chk("ev_readFlag", int'(readFlag), 1);
      chk("ev_rEnable", int'(rEnable), 0);
      @(negedge clk); @(negedge clk);
      chk("ev_waddr", int'(waddr), 6);
      chk("ev_newCounts", int'(newCounts), 1);
      chk("ev_wEnable", int'(wEnable), 1);
      // same-bin streak on bin 63
      for (int k = 0; k < 5; k++) begin
         wrEn = (k < 3); data = 10'd1022;
         @(negedge clk);
         if (k >= 2) begin
            chk("streak_waddr", int'(waddr), 63);
            chk("streak_newCounts", int'(newCounts), k - 1);
         end
      end
      wrEn = 0;
      // commit-stage forwarding 511, 200, 511
      for (int k = 0; k < 5; k++) begin
         wrEn = (k < 3); data = (k < 3) ? 10'(bins3[k]) : '0;
         @(negedge clk);
         if (k >= 2) begin
            chk("fwd_waddr", int'(waddr), wa3[k-2]);
            chk("fwd_newCounts", int'(newCounts), nc3[k-2]);
         end
      end
      wrEn = 0;
      randCycles(400, 8, 11);
      // 256 events on bin 5: the 255th reaches full scale, the 256th saturates or wraps
      for (int k = 0; k < 259; k++) begin
         wrEn = (k < 256); data = 10'd80;
         @(negedge clk);
         if (k == 256) chk("full_newCounts", int'(newCounts), 255);
`ifdef SIFH_SAT_EN
         if (k == 257) chk("ovf_newCounts", int'(newCounts), 255);
`else
         if (k == 257) chk("ovf_newCounts", int'(newCounts), 0);
`endif
      end
      wrEn = 0;
      randCycles(20, 0, 63);
      // reset mid-operation, together with an event
      res = 1; wrEn = 1; data = 10'd80;
      @(negedge clk);
      chk("midrst_wEnable", int'(wEnable), 0);
      chk("midrst_readFlag", int'(readFlag), 0);
      res = 0;
      for (int i = 0; i < 64; i++) begin
         wrEn = $urandom_range(0, 1) == 1; data = 10'($urandom);
         @(negedge clk);
         if (i == 0) begin
            chk("restart_waddr", int'(waddr), 0);
            chk("restart_wEnable", int'(wEnable), 1);
         end
         chk("clr2_readFlag", int'(readFlag), 0);
      end
      randCycles(300, 0, 63);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 64; i++) chk("ram_bin", int'(mem[i]), hist[i]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
